// File: rtl/ad9826_cfg_sequencer_if.sv
// Host request/response bus of the AD9826 config sequencer.
// master: host side (valid/rw/addr/wdata out); slave: sequencer side (ready/rsp out).
interface ad9826_cfg_sequencer_if;
  logic       host_valid;
  logic       host_ready;
  logic       host_rw;
  logic [2:0] host_addr;
  logic [8:0] host_wdata;
  logic       rsp_valid;
  logic [8:0] rsp_data;

  modport master (
    output host_valid, host_rw, host_addr, host_wdata,
    input  host_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  host_valid, host_rw, host_addr, host_wdata,
    output host_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/ad9826_cfg_sequencer.sv
// AD9826 config sequencer: writes power-up table, then serves host requests.
// Ports: clk, rst_n, host (slave bus), init_done, cfg_error, engine side
// (ad_config_in, toggle, busy, ad_config_out, config_out_avail,
// config_out_recieved). Optional AD9826_SEQ_READBACK_EN: verify each
// table write with a readback.
module ad9826_cfg_sequencer #(
  parameter int          NUM_REGS       = 8,
  parameter logic [71:0] INIT_TABLE     = 72'h0,
  parameter int          STARTUP_CYCLES = 1024,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  ad9826_cfg_sequencer_if.slave host,
  output logic        init_done,
  output logic        cfg_error,
  output logic [15:0] ad_config_in,
  output logic        toggle,
  input  logic        busy,
  input  logic [15:0] ad_config_out,
  input  logic        config_out_avail,
  output logic        config_out_recieved
);

  localparam int TMAX = (STARTUP_CYCLES > TIMEOUT_CYCLES) ?
                        STARTUP_CYCLES : TIMEOUT_CYCLES;
  localparam int TW = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_STARTUP, S_LOAD, S_REQ, S_XFER,
    S_RDACK, S_NEXT, S_IDLE, S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    index_q, index_d;
  logic          verify_q, verify_d;
  logic          rw_q, rw_d;
  logic [2:0]    addr_q, addr_d;
  logic [8:0]    wdata_q, wdata_d;
  logic [15:0]   cfg_q, cfg_d;
  logic          toggle_q, toggle_d;
  logic          rcv_q, rcv_d;
  logic          host_ready_q, host_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [8:0]    rsp_data_q, rsp_data_d;
  logic          init_done_q, init_done_d;
  logic          cfg_error_q, cfg_error_d;
  logic          busy_m_q, busy_s_q;
  logic          avail_m_q, avail_s_q;

  logic       cur_rw;
  logic [2:0] cur_addr;
  logic [8:0] cur_data;
  logic [8:0] tbl_val;
  logic       last;
  logic       timeout;
  logic       unused_cfg_out;

  assign tbl_val  = INIT_TABLE[9*int'(index_q) +: 9];
  // Init phase: verify_q selects the readback half of a table entry.
  assign cur_rw   = init_done_q ? rw_q : verify_q;
  assign cur_addr = init_done_q ? addr_q : index_q;
  assign cur_data = init_done_q ? wdata_q : tbl_val;
  assign last     = (index_q == 3'(NUM_REGS - 1));
  assign timeout  = (timer_q == TW'(TIMEOUT_CYCLES));
  assign unused_cfg_out = ^ad_config_out[15:9];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_STARTUP;
      timer_q      <= '0;
      index_q      <= '0;
      verify_q     <= 1'b0;
      rw_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cfg_q        <= '0;
      toggle_q     <= 1'b0;
      rcv_q        <= 1'b0;
      host_ready_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      init_done_q  <= 1'b0;
      cfg_error_q  <= 1'b0;
      busy_m_q     <= 1'b0;
      busy_s_q     <= 1'b0;
      avail_m_q    <= 1'b0;
      avail_s_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      index_q      <= index_d;
      verify_q     <= verify_d;
      rw_q         <= rw_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cfg_q        <= cfg_d;
      toggle_q     <= toggle_d;
      rcv_q        <= rcv_d;
      host_ready_q <= host_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      init_done_q  <= init_done_d;
      cfg_error_q  <= cfg_error_d;
      busy_m_q     <= busy;
      busy_s_q     <= busy_m_q;
      avail_m_q    <= config_out_avail;
      avail_s_q    <= avail_m_q;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_STARTUP:
        if (timer_q == TW'(STARTUP_CYCLES - 1)) state_d = S_LOAD;
      S_LOAD: state_d = S_REQ;
      S_REQ:
        if (timeout) state_d = S_ERR;
        else if (busy_s_q) state_d = S_XFER;
      S_XFER:
        if (timeout) state_d = S_ERR;
        else if (cur_rw && avail_s_q) state_d = S_RDACK;
        else if (!cur_rw && !busy_s_q) state_d = S_NEXT;
      S_RDACK:
        if (timeout) state_d = S_ERR;
        else if (!busy_s_q) state_d = S_NEXT;
      S_NEXT:
        if (init_done_q) state_d = S_IDLE;
`ifdef AD9826_SEQ_READBACK_EN
        else if (!verify_q) state_d = S_LOAD;
        else if (rsp_data_q != tbl_val) state_d = S_ERR;
`endif
        else if (last) state_d = S_IDLE;
        else state_d = S_LOAD;
      S_IDLE:
        if (host.host_valid) state_d = S_LOAD;
      S_ERR: state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  always_comb begin
    timer_d      = (state_d != state_q) ? '0 : timer_q + 1'b1;
    index_d      = index_q;
    verify_d     = verify_q;
    rw_d         = rw_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cfg_d        = cfg_q;
    toggle_d     = toggle_q;
    rcv_d        = rcv_q;
    host_ready_d = 1'b0;
    rsp_valid_d  = 1'b0;
    rsp_data_d   = rsp_data_q;
    init_done_d  = init_done_q;
    cfg_error_d  = cfg_error_q;
    unique case (state_q)
      S_LOAD: begin
        cfg_d    = {cur_rw, cur_addr, 3'b000,
                    cur_rw ? 9'h000 : cur_data};
        toggle_d = 1'b1;
      end
      S_REQ:
        if (state_d != S_REQ) toggle_d = 1'b0;
      S_XFER:
        if (state_d == S_RDACK) begin
          rsp_data_d = ad_config_out[8:0];
          rcv_d      = 1'b1;
        end
      S_RDACK:
        if (state_d != S_RDACK) rcv_d = 1'b0;
      S_NEXT:
        if (init_done_q) begin
          rsp_valid_d = 1'b1;
          if (!rw_q) rsp_data_d = wdata_q;
        end else begin
`ifdef AD9826_SEQ_READBACK_EN
          verify_d = !verify_q;
          if (verify_q) begin
`endif
            if (last) begin
              init_done_d = 1'b1;
              index_d     = '0;
            end else begin
              index_d = index_q + 3'd1;
            end
`ifdef AD9826_SEQ_READBACK_EN
          end
`endif
        end
      S_IDLE:
        if (host.host_valid) begin
          host_ready_d = 1'b1;
          rw_d         = host.host_rw;
          addr_d       = host.host_addr;
          wdata_d      = host.host_wdata;
        end
      default: ;
    endcase
    if (state_d == S_ERR) begin
      cfg_error_d = 1'b1;
      toggle_d    = 1'b0;
      rcv_d       = 1'b0;
    end
  end

  assign host.host_ready     = host_ready_q;
  assign host.rsp_valid      = rsp_valid_q;
  assign host.rsp_data       = rsp_data_q;
  assign init_done           = init_done_q;
  assign cfg_error           = cfg_error_q;
  assign ad_config_in        = cfg_q;
  assign toggle              = toggle_q;
  assign config_out_recieved = rcv_q;

endmodule

// File: tb/tb_ad9826_cfg_sequencer.sv
// Scoreboard bench for ad9826_cfg_sequencer with a behavioural engine model.
// Expected frames/responses are queued at stimulus time and popped on output.
module tb_ad9826_cfg_sequencer;

  localparam int NR = 8;
  localparam int SU = 16;
  localparam int TO = 64;
`ifdef AD9826_SEQ_READBACK_EN
  localparam int FR_INIT = 2 * NR;
  localparam int FR_T5   = 9;
`else
  localparam int FR_INIT = NR;
  localparam int FR_T5   = 5;
`endif

  function automatic logic [71:0] mk_tbl();
    logic [71:0] t;
    t = '0;
    for (int i = 0; i < NR; i++) t[9*i +: 9] = 9'h0C8 + 9'(i);
    return t;
  endfunction

  localparam logic [71:0] TBL = mk_tbl();

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        init_done, cfg_error, toggle, rcv;
  logic        busy, avail;
  logic [15:0] cfg_in, cfg_out;

  ad9826_cfg_sequencer_if hif();

  ad9826_cfg_sequencer #(
    .NUM_REGS(NR), .INIT_TABLE(TBL),
    .STARTUP_CYCLES(SU), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .host(hif),
    .init_done(init_done), .cfg_error(cfg_error),
    .ad_config_in(cfg_in), .toggle(toggle), .busy(busy),
    .ad_config_out(cfg_out), .config_out_avail(avail),
    .config_out_recieved(rcv)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [15:0] q_frm[$];
  logic [8:0]  q_rsp[$];
  logic [8:0]  regs[8];
  bit          no_busy = 1'b0;
  int          corrupt_addr = -1;
  int          frames = 0;
  int          to_len = -1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_table();
    for (int i = 0; i < NR; i++) begin
      q_frm.push_back({1'b0, 3'(i), 3'b000, TBL[9*i +: 9]});
`ifdef AD9826_SEQ_READBACK_EN
      q_frm.push_back({1'b1, 3'(i), 3'b000, 9'h000});
`endif
    end
  endtask

  task automatic chk_reset(input string p);
    check({p, "_toggle"}, toggle, 0);
    check({p, "_rcv"}, rcv, 0);
    check({p, "_cfg_in"}, cfg_in, 0);
    check({p, "_ready"}, hif.host_ready, 0);
    check({p, "_rsp_valid"}, hif.rsp_valid, 0);
    check({p, "_rsp_data"}, hif.rsp_data, 0);
    check({p, "_init_done"}, init_done, 0);
    check({p, "_cfg_error"}, cfg_error, 0);
  endtask

  task automatic host_req(input logic rw, input logic [2:0] a,
                          input logic [8:0] d, input bit want_rsp,
                          input logic [8:0] exp_rsp);
    int n;
    q_frm.push_back({rw, a, 3'b000, rw ? 9'h000 : d});
    if (want_rsp) q_rsp.push_back(exp_rsp);
    hif.host_rw    = rw;
    hif.host_addr  = a;
    hif.host_wdata = d;
    hif.host_valid = 1'b1;
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (!hif.host_ready && n < 3000);
    check("host_ready", hif.host_ready, 1);
    check("ready_after_init", init_done, 1);
    hif.host_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (q_rsp.size() != 0 && n < 2000) begin
      cyc(1);
      n++;
    end
    check("rsp_drained", q_rsp.size(), 0);
  endtask

  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (!init_done && n < 5000) begin
      cyc(1);
      n++;
    end
    check(tag, init_done, 1);
  endtask

  // Engine model: accepts a frame on toggle, acts on it, checks the word.
  initial begin
    logic [15:0] w;
    int          n;
    busy = 1'b0;
    avail = 1'b0;
    cfg_out = '0;
    for (int i = 0; i < 8; i++) regs[i] = '0;
    forever begin
      cyc(1);
      if (rst_n === 1'b1 && toggle === 1'b1) begin
        w = cfg_in;
        frames++;
        if (q_frm.size() == 0) check("frame_queue", q_frm.size(), 1);
        else check("frame", w, q_frm.pop_front());
        if (no_busy) begin
          n = 1;
          while (toggle && rst_n && n < 10000) begin
            cyc(1);
            if (toggle) n++;
          end
          to_len = n;
        end else begin
          cyc(3);
          busy = 1'b1;
          if (w[15]) begin
            cyc(3);
            cfg_out = {7'h0, regs[w[14:12]] ^
                      ((int'(w[14:12]) == corrupt_addr) ? 9'h001 : 9'h000)};
            avail = 1'b1;
            n = 0;
            while (!rcv && rst_n && n < 200) begin
              cyc(1);
              n++;
            end
            if (rst_n) check("rcv_rise", rcv, 1);
            avail = 1'b0;
            cyc(3);
            if (rst_n) check("rcv_hold", rcv, 1);
            busy = 1'b0;
            n = 0;
            while (rcv && rst_n && n < 10) begin
              cyc(1);
              n++;
            end
            if (rst_n) check("rcv_fall", rcv, 0);
          end else begin
            regs[w[14:12]] = w[8:0];
            cyc(5);
            busy = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      cyc(1);
      if (hif.rsp_valid === 1'b1) begin
        if (q_rsp.size() == 0) check("rsp_queue", q_rsp.size(), 1);
        else check("rsp_data", hif.rsp_data, q_rsp.pop_front());
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1);
  end

  initial begin
    int n;
    bit saw;
    hif.host_valid = 1'b0;
    hif.host_rw    = 1'b0;
    hif.host_addr  = '0;
    hif.host_wdata = '0;
    #3 rst_n = 1'b0;
    cyc(3);
    chk_reset("rst");

    // T1 + T3: table writes, with a host write queued during init
    push_table();
    frames = 0;
    rst_n = 1'b1;
    fork
      host_req(1'b0, 3'd5, 9'h0FF, 1'b1, 9'h0FF);
      begin
        wait_init("t1_init_done");
        check("t1_frames", frames, FR_INIT);
      end
    join
    wait_rsp();
    check("t3_frames", frames, FR_INIT + 1);

    // T2: host read; boundary addr 7 with all-ones data
    regs[3] = 9'h1A5;
    host_req(1'b1, 3'd3, 9'h000, 1'b1, 9'h1A5);
    wait_rsp();
    host_req(1'b0, 3'd7, 9'h1FF, 1'b1, 9'h1FF);
    wait_rsp();
    host_req(1'b1, 3'd7, 9'h0AA, 1'b1, 9'h1FF);
    wait_rsp();
    check("t2_frames_left", q_frm.size(), 0);

    // T5: reset in the middle of the entry-4 frame
    rst_n = 1'b0;
    cyc(2);
    q_frm.delete();
    push_table();
    frames = 0;
    rst_n = 1'b1;
    n = 0;
    while (!(frames == FR_T5 && busy) && n < 3000) begin
      cyc(1);
      n++;
    end
    check("t5_reached", frames, FR_T5);
    check("t5_toggle_pre", toggle, 1);
    #2 rst_n = 1'b0;
    #1 check("t5_toggle_rst", toggle, 0);
    chk_reset("t5");
    cyc(3);
    q_frm.delete();
    push_table();
    frames = 0;
    rst_n = 1'b1;
    wait_init("t5_init_done");
    check("t5_frames", frames, FR_INIT);
    check("t5_frames_left", q_frm.size(), 0);

    // T4: engine never answers
    no_busy = 1'b1;
    host_req(1'b0, 3'd1, 9'h055, 1'b0, 9'h000);
    n = 0;
    while (!cfg_error && n < 4 * TO) begin
      cyc(1);
      n++;
    end
    check("t4_cfg_error", cfg_error, 1);
    check("t4_toggle", toggle, 0);
    cyc(2);
    check("t4_toggle_len", to_len, TO + 1);
    hif.host_valid = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cyc(1);
      if (hif.host_ready) saw = 1'b1;
    end
    hif.host_valid = 1'b0;
    check("t4_no_ready", saw, 0);
    check("t4_err_sticky", cfg_error, 1);
    no_busy = 1'b0;

`ifdef AD9826_SEQ_READBACK_EN
    // T6: corrupted readback of addr 2
    rst_n = 1'b0;
    cyc(2);
    q_frm.delete();
    push_table();
    corrupt_addr = 2;
    frames = 0;
    rst_n = 1'b1;
    n = 0;
    while (!cfg_error && n < 3000) begin
      cyc(1);
      n++;
    end
    check("t6_cfg_error", cfg_error, 1);
    check("t6_init_done", init_done, 0);
    check("t6_frames", frames, 6);
    cyc(20);
    check("t6_init_stays", init_done, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
